rr_select_arbiter: RTL and testbench

Four-channel round-robin arbiter that produces the 2-bit select pair (s0, s1) consumed directly by the team's 2-to-4 one-hot decoder, plus a grant-valid qualifier. It owns the shared resource and rotates it fairly among four requesters. Each grant is held until the owner signals completion, drops its request, or exceeds a programmable hold limit while others wait. It sits immediately upstream of the decoder; decoder outputs are only meaningful while gnt_valid is high.

---
 rtl/rr_select_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_select_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter.sv
// Four-channel round-robin arbiter driving the {s0,s1} select pair of a 2-to-4 decoder.
// Grants are held until done, request drop, or the hold limit while another channel waits.
module rr_select_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       s0,
    output logic       s1,
    output logic       gnt_valid,
    output logic       expire
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       expire_q, expire_d;

    logic [2:0] win_s;
    logic       owner_req_s;
    logic       other_req_s;

    // Returns {found, index}; scanning backwards lets the highest-priority hit (ptr+1) win.
    function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = p + k[1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Arbitration helpers derived from the current owner pointer.
    always_comb begin
        win_s       = pick_winner(req, ptr_q);
        owner_req_s = req[ptr_q];
        other_req_s = |(req & ~(4'b0001 << ptr_q));
    end

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hcnt_d      = hcnt_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        gnt_valid_d = gnt_valid_q;
        expire_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_s[2]) begin
                    s0_d        = win_s[1];
                    s1_d        = win_s[0];
                    ptr_d       = win_s[1:0];
                    hcnt_d      = 8'd1;
                    gnt_valid_d = 1'b1;
                    state_d     = ST_GRANT;
                end else begin
                    gnt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    gnt_valid_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else if (!owner_req_s) begin
                    gnt_valid_d = 1'b0;
                    state_d     = ST_RELEASE;
                end else if ((hcnt_q >= HOLD_LIM) && other_req_s) begin
                    gnt_valid_d = 1'b0;
                    expire_d    = 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    // Saturate so an uncontested grant can be held forever.
                    hcnt_d      = (hcnt_q == 8'hFF) ? hcnt_q : hcnt_q + 8'd1;
                    gnt_valid_d = 1'b1;
                    state_d     = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                gnt_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                gnt_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd3;
            hcnt_q      <= 8'd0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            gnt_valid_q <= 1'b0;
            expire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hcnt_q      <= hcnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            gnt_valid_q <= gnt_valid_d;
            expire_q    <= expire_d;
        end
    end

    assign s0        = s0_q;
    assign s1        = s1_q;
    assign gnt_valid = gnt_valid_q;
    assign expire    = expire_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, a monitor checks each completed grant.
module tb_rr_select_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       s0;
    logic       s1;
    logic       gnt_valid;
    logic       expire;

    typedef struct {
        logic [1:0] ch;
        int         len;
        logic       ex;
        int         gap;   // 0 means the preceding idle gap is not checked
    } grant_t;

    grant_t exp_q[$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    int     stray  = 0;

    rr_select_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .s0        (s0),
        .s1        (s1),
        .gnt_valid (gnt_valid),
        .expire    (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req_v);
        n_cmp++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!gnt_valid && n < 50) begin
            tick();
            n++;
        end
        chk("grant_wait", int'(gnt_valid), 1);
    endtask

    task automatic wait_release();
        int n = 0;
        while (gnt_valid && n < 50) begin
            tick();
            n++;
        end
        chk("release_wait", int'(gnt_valid), 0);
    endtask

    task automatic push(input logic [1:0] ch, input int len, input logic ex, input int gap);
        grant_t g;
        g.ch  = ch;
        g.len = len;
        g.ex  = ex;
        g.gap = gap;
        exp_q.push_back(g);
    endtask

    // Monitor: measures each grant and compares it when gnt_valid falls.
    initial begin
        logic       prev_v;
        logic [1:0] cur_ch;
        int         cur_len;
        int         cur_gap;
        int         low_cnt;
        logic       moved;
        grant_t     e;
        prev_v  = 1'b0;
        cur_ch  = 2'd0;
        cur_len = 0;
        cur_gap = 0;
        low_cnt = 0;
        moved   = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_valid) begin
                if (!prev_v) begin
                    cur_ch  = {s0, s1};
                    cur_len = 0;
                    cur_gap = low_cnt;
                    moved   = 1'b0;
                end else if ({s0, s1} != cur_ch) begin
                    moved = 1'b1;
                end
                if (expire) stray++;
                cur_len++;
            end else if (prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(cur_ch), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_channel", int'(cur_ch), int'(e.ch));
                    chk("grant_length", cur_len, e.len);
                    chk("expire_pulse", int'(expire), int'(e.ex));
                    chk("select_stable", int'(moved), 0);
                    if (e.gap != 0) chk("idle_gap", cur_gap, e.gap);
                end
                low_cnt = 1;
            end else begin
                if (expire) stray++;
                low_cnt++;
            end
            prev_v = gnt_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        tick();
        chk("reset_s0", int'(s0), 0);
        chk("reset_s1", int'(s1), 0);
        chk("reset_gnt_valid", int'(gnt_valid), 0);
        chk("reset_expire", int'(expire), 0);

        // Channel 1 first, then channel 3 after done.
        rst = 1'b0;
        req = 4'b1010;
        push(2'd1, 3, 1'b0, 0);
        push(2'd3, 1, 1'b0, 2);
        tick();
        chk("grant_latency", int'(gnt_valid), 1);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_grant();
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;

        // Full contention with done every grant: order 0,1,2,3,0.
        tick();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            push(order[g], 2, 1'b0, (g == 0) ? 0 : 2);
        end
        for (int g = 0; g < 5; g++) begin
            wait_grant();
            tick();
            done = 1'b1;
            if (g == 4) req = 4'b0000;
            tick();
            done = 1'b0;
        end

        // Hold limit with contention, then uncontested long hold.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        push(2'd0, 4, 1'b1, 0);
        push(2'd1, 6, 1'b0, 2);
        wait_grant();
        wait_release();
        wait_grant();
        req = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0001;
        push(2'd0, 23, 1'b0, 0);
        wait_grant();
        for (int i = 0; i < 22; i++) tick();
        req = 4'b0000;
        tick();

        // Owner drops its request; select holds 10 afterwards.
        tick();
        req = 4'b0100;
        push(2'd2, 3, 1'b0, 0);
        wait_grant();
        tick();
        tick();
        req = 4'b0000;
        tick();
        chk("drop_release_valid", int'(gnt_valid), 0);
        chk("drop_release_sel", int'({s0, s1}), 2);
        tick();
        chk("drop_idle_sel", int'({s0, s1}), 2);
        chk("drop_idle_expire", int'(expire), 0);

        // done coincides with the hold limit under contention.
        req = 4'b0011;
        push(2'd0, 4, 1'b0, 0);
        wait_grant();
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        tick();

        // Reset in the middle of a channel-2 grant.
        tick();
        req = 4'b0100;
        push(2'd2, 2, 1'b0, 0);
        wait_grant();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_reset_s0", int'(s0), 0);
        chk("mid_reset_s1", int'(s1), 0);
        chk("mid_reset_valid", int'(gnt_valid), 0);
        chk("mid_reset_expire", int'(expire), 0);
        rst = 1'b0;
        req = 4'b0101;
        push(2'd0, 1, 1'b0, 0);
        wait_grant();
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;

        for (int i = 0; i < 5; i++) tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("stray_expire", stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
